fifo_serial_tx: RTL and testbench

Downstream drain stage for the 4-bit, 4-deep FIFO. Whenever the FIFO is non-empty, it pops one nibble and serialises it onto a single-wire, UART-style line: a start bit, 4 data bits LSB first, an optional even-parity bit, then a stop bit. It is the only consumer of the FIFO's `data_out`/`fifo_empty`, and it drives the FIFO's `pop` input.

---
 rtl/fifo_serial_tx_if.sv | 14 +
 rtl/fifo_serial_tx.sv | 137 +++++++++++++
 tb/tb_fifo_serial_tx.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_serial_tx_if.sv
// rtl/fifo_serial_tx_if.sv - pop handshake between the 4x4 FIFO and the serial drain stage
// Signals:
//   fifo_data  - nibble at the FIFO head, valid while fifo_empty = 0
//   fifo_empty - FIFO empty flag
//   fifo_pop   - one-cycle pop strobe from the drain stage
// Modports: master = FIFO side, slave = drain (serializer) side.
interface fifo_serial_tx_if;
    logic [3:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_pop;

    modport master (output fifo_data, output fifo_empty, input fifo_pop);
    modport slave  (input fifo_data, input fifo_empty, output fifo_pop);
endinterface

// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - drains the nibble FIFO onto a UART-style serial line
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous active-low reset
//   fifo       - slave side of fifo_serial_tx_if (fifo_data, fifo_empty in; fifo_pop out)
//   tx_out     - serial line, idles high: start, 4 data bits LSB first, [even parity], stop
//   busy       - high from start bit through stop bit
//   frame_done - one-cycle pulse in the final cycle of each stop bit
module fifo_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    fifo_serial_tx_if.slave fifo,
    output logic            tx_out,
    output logic            busy,
    output logic            frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [1:0]  bit_idx_q;
    logic [3:0]  shift_q;
    logic        parity_q;
    logic        tx_q;
    logic        busy_q;
    logic        done_q;
    logic        pop_q;
    logic        bit_end;

    assign bit_end = (cnt_q == LAST_CNT);

    // Line outputs are registered from the current state, so the serial
    // waveform trails the FSM by one cycle; the pop strobe is registered
    // from the pop decision itself so the FIFO sees it on the very next edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pop_q     <= 1'b0;
        end else begin
            pop_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b1;
            tx_q   <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    if (!fifo.fifo_empty) begin
                        shift_q  <= fifo.fifo_data;
                        parity_q <= ^fifo.fifo_data;
                        pop_q    <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    tx_q <= 1'b0;
                    if (bit_end) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    tx_q <= shift_q[0];
                    if (bit_end) begin
                        cnt_q   <= '0;
                        shift_q <= {1'b0, shift_q[3:1]};
                        if (bit_idx_q == 2'd3) begin
                            state_q <= PARITY_EN ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_PARITY: begin
                    tx_q <= parity_q;
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        done_q <= 1'b1;
                        cnt_q  <= '0;
                        // Second pop decision point: chain the next frame with no idle gap.
                        if (!fifo.fifo_empty) begin
                            shift_q  <= fifo.fifo_data;
                            parity_q <= ^fifo.fifo_data;
                            pop_q    <= 1'b1;
                            state_q  <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign tx_out        = tx_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign fifo.fifo_pop = pop_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb/tb_fifo_serial_tx.sv - self-checking bench for fifo_serial_tx (no parity and parity instances)
module tb_fifo_serial_tx;

    localparam int CPB = 4;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } samp_t;

    localparam samp_t IDLE_SAMP = '{tx: 1'b1, busy: 1'b0, done: 1'b0};

    logic       clk;
    logic       reset;
    logic       rst_s;
    logic [1:0] tx, bz, fd, pp, emp, fake, prev_pop, prev_busy;
    logic [3:0] dat [2];

    logic [3:0] fq    [2][$];
    samp_t      exq   [2][$];
    logic       trace [2][$];
    int         pop_cnt  [2];
    int         done_cnt [2];
    int         rise_cnt [2];

    int n_vec = 0;
    int n_err = 0;

    fifo_serial_tx_if bus0 ();
    fifo_serial_tx_if bus1 ();

    assign bus0.fifo_data  = dat[0];
    assign bus0.fifo_empty = emp[0];
    assign bus1.fifo_data  = dat[1];
    assign bus1.fifo_empty = emp[1];
    assign pp[0] = bus0.fifo_pop;
    assign pp[1] = bus1.fifo_pop;

    fifo_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .fifo(bus0),
        .tx_out(tx[0]), .busy(bz[0]), .frame_done(fd[0])
    );

    fifo_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .fifo(bus1),
        .tx_out(tx[1]), .busy(bz[1]), .frame_done(fd[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h want %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    function automatic void refresh();
        for (int i = 0; i < 2; i++) begin
            emp[i] = fake[i] ? 1'b0 : (fq[i].size() == 0);
            dat[i] = fake[i] ? 4'hF : ((fq[i].size() != 0) ? fq[i][0] : 4'h0);
        end
    endfunction

    // Expected line image of one frame, one entry per clock cycle.
    function automatic void add_frame(int i, logic [3:0] d);
        logic [6:0] bits;
        int         nb;
        bits = {1'b0, d[0], d[1], d[2], d[3], ^d, 1'b1};
        nb   = 6;
        if (i == 1) begin
            nb = 7;
        end else begin
            bits = {bits[6:2], 1'b1, 1'b0};
        end
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < CPB; c++) begin
                exq[i].push_back('{tx: bits[6 - k], busy: 1'b1,
                                   done: (k == nb - 1) && (c == CPB - 1)});
            end
        end
    endfunction

    always @(posedge clk) rst_s <= reset;

    // Bench-side FIFO: retire the head on a pop seen at the edge.
    always @(posedge clk) begin
        logic [1:0] p;
        p = pp;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (p[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        end
        refresh();
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            samp_t e;
            if (!rst_s) begin
                exq[i].delete();
                e = IDLE_SAMP;
            end else if (exq[i].size() != 0) begin
                e = exq[i].pop_front();
            end else begin
                e = IDLE_SAMP;
            end
            chk("tx_out", i, 32'(tx[i]), 32'(e.tx));
            chk("busy", i, 32'(bz[i]), 32'(e.busy));
            chk("frame_done", i, 32'(fd[i]), 32'(e.done));
            if (!rst_s) begin
                chk("fifo_pop_in_reset", i, 32'(pp[i]), 32'd0);
            end else if (pp[i]) begin
                chk("fifo_pop_legal", i,
                    {29'd0, fq[i].size() != 0, e.done || !e.busy, !prev_pop[i]}, 32'd7);
                if (fq[i].size() != 0) add_frame(i, fq[i][0]);
            end
            if (bz[i]) trace[i].push_back(tx[i]);
            if (bz[i] && !prev_busy[i]) rise_cnt[i]++;
            if (pp[i]) pop_cnt[i]++;
            if (fd[i]) done_cnt[i]++;
            prev_pop[i]  = pp[i];
            prev_busy[i] = bz[i];
        end
    end

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            trace[i].delete();
            pop_cnt[i]  = 0;
            done_cnt[i] = 0;
            rise_cnt[i] = 0;
        end
    endtask

    task automatic push(int i, logic [3:0] v);
        fq[i].push_back(v);
        refresh();
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(int i);
        int k;
        for (k = 0; k < 2000; k++) begin
            tick(1);
            if (fq[i].size() == 0 && exq[i].size() == 0 && !bz[i] && !fake[i]) break;
        end
        chk("drain_timeout", i, 32'(k < 2000), 32'd1);
        tick(3);
    endtask

    function automatic logic [31:0] bits_of(int i, int n);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < n; j++) begin
            v = {v[30:0], (CPB * j < trace[i].size()) ? trace[i][CPB * j] : 1'bx};
        end
        return v;
    endfunction

    initial begin
        reset     = 1'b0;
        fake      = '0;
        prev_pop  = '0;
        prev_busy = '0;
        clear_stats();
        refresh();

        // Reset hold with an empty FIFO.
        tick(20);
        chk("reset_hold_tx", 0, 32'(tx), 32'h3);
        chk("reset_hold_busy", 0, 32'(bz), 32'h0);
        chk("reset_hold_pops", 0, 32'(pop_cnt[0] + pop_cnt[1]), 32'd0);
        reset = 1'b1;
        tick(2);
        clear_stats();

        // Single 4'hA frame, no parity.
        push(0, 4'hA);
        wait_done(0);
        chk("a_busy_cycles", 0, 32'(trace[0].size()), 32'd24);
        chk("a_bits", 0, bits_of(0, 6), 32'b001011);
        chk("a_pops", 0, 32'(pop_cnt[0]), 32'd1);
        chk("a_frame_done", 0, 32'(done_cnt[0]), 32'd1);
        clear_stats();

        // Parity instance, 7 then 3 back-to-back.
        push(1, 4'h7);
        push(1, 4'h3);
        wait_done(1);
        chk("par_busy_cycles", 1, 32'(trace[1].size()), 32'd56);
        chk("par_bits", 1, bits_of(1, 14), 32'b01110110110001);
        chk("par_pops", 1, 32'(pop_cnt[1]), 32'd2);
        chk("par_frame_done", 1, 32'(done_cnt[1]), 32'd2);
        chk("par_no_gap", 1, 32'(rise_cnt[1]), 32'd1);
        clear_stats();

        // Full FIFO drain, four frames in order.
        push(0, 4'h1);
        push(0, 4'h2);
        push(0, 4'h4);
        push(0, 4'h8);
        wait_done(0);
        tick(10);
        chk("fill_busy_cycles", 0, 32'(trace[0].size()), 32'd96);
        chk("fill_bits", 0, bits_of(0, 24), 32'b010001001001000101000011);
        chk("fill_pops", 0, 32'(pop_cnt[0]), 32'd4);
        chk("fill_no_gap", 0, 32'(rise_cnt[0]), 32'd1);
        chk("fill_empty", 0, 32'(emp[0]), 32'd1);
        clear_stats();

        // Reset in the middle of data bit 2.
        push(0, 4'h9);
        begin
            int k;
            for (k = 0; k < 200; k++) begin
                tick(1);
                if (trace[0].size() == 14) break;
            end
            chk("mid_frame_reach", 0, 32'(k < 200), 32'd1);
        end
        reset = 1'b0;
        tick(1);
        chk("mid_reset_tx", 0, 32'(tx[0]), 32'd1);
        chk("mid_reset_busy", 0, 32'(bz[0]), 32'd0);
        reset = 1'b1;
        tick(20);
        chk("post_reset_idle_busy", 0, 32'(bz[0]), 32'd0);
        chk("post_reset_idle_tx", 0, 32'(tx[0]), 32'd1);
        chk("post_reset_pops", 0, 32'(pop_cnt[0]), 32'd1);
        clear_stats();

        // fifo_empty toggling during the data bits must be ignored.
        push(0, 4'h5);
        tick(4);
        for (int c = 0; c < 12; c++) begin
            fake[0] = ~fake[0];
            refresh();
            tick(1);
        end
        fake[0] = 1'b0;
        refresh();
        wait_done(0);
        chk("toggle_busy_cycles", 0, 32'(trace[0].size()), 32'd24);
        chk("toggle_bits", 0, bits_of(0, 6), 32'b010101);
        chk("toggle_pops", 0, 32'(pop_cnt[0]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
